debug_cmd_rx: RTL
=================

# debug_cmd_rx

Receive-side counterpart of the debug UART port. Pops bytes from the UART RX FIFO interface and parses fixed 4-byte command frames (start, code, data, checksum). Presents decoded commands to user logic as a one-cycle strobe. Runs a host-kicked watchdog: frame code 0x65 reloads it, and expiry raises a level flag.

## Interface
- WDT_TIMEOUT, 32'h00682EFF, watchdog reload value in clock cycles
- BYTE_TIMEOUT, 16'd50000, maximum idle cycles between bytes inside a frame
- START_BYTE, 8'h2D, frame start marker
- KICK_CODE, 8'h65, code byte that kicks the watchdog
---
- i_clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_rdata  in  8  RX byte; valid while i_rready=1
- i_rready  in  1  RX byte available
- o_rreq  out  1  pop strobe; i_rdata is captured in the same cycle
- o_cmd_code  out  8  decoded code; held until the next valid frame
- o_cmd_data  out  8  decoded data; held until the next valid frame
- o_cmd_valid  out  1  one-cycle strobe for a valid non-kick frame
- o_wdt_kick  out  1  one-cycle strobe for a valid kick frame
- o_wdt_expired  out  1  level; watchdog has reached 0
- o_err  out  1  one-cycle error strobe
- o_err_code  out  2  1 = checksum error, 2 = byte timeout; held until the next error
- o_frame_cnt  out  8  valid frames received (kicks included); wraps 255 -> 0
- o_err_cnt  out  8  errors; saturates at 255

## Operation
- Reset values:
  - All outputs are 0.
  - FSM is IDLE.
  - Watchdog counter is WDT_TIMEOUT.
  - Byte-timeout counter is 0.
- RX handshake:
  - o_rreq=1 when i_rready=1 and o_rreq was 0 in the previous cycle.
  - o_rreq is never high in two consecutive cycles.
  - Each o_rreq cycle consumes exactly one byte.
- FSM states, one transition per accepted byte:
  - IDLE: a byte equal to START_BYTE goes to CODE. Any other byte is discarded silently and the FSM stays in IDLE.
  - CODE: store the byte as code; go to DATA.
  - DATA: store the byte as data; go to CHECK.
  - CHECK: compare the byte with code XOR data.
    - Match and code == KICK_CODE: o_wdt_kick strobe.
    - Match and any other code: update o_cmd_code/o_cmd_data and strobe o_cmd_valid.
    - Match in either case: o_frame_cnt increments.
    - Mismatch: o_err strobe, o_err_code=1, o_err_cnt increments. o_cmd_code/o_cmd_data are unchanged.
    - Every outcome returns the FSM to IDLE.
- No escaping. A START_BYTE value received in CODE, DATA or CHECK is treated as ordinary data.
- Byte timeout:
  - In CODE, DATA or CHECK, the counter increments every cycle with no accepted byte. It clears on each accepted byte.
  - When the counter reaches BYTE_TIMEOUT: o_err strobe, o_err_code=2, o_err_cnt increments, FSM goes to IDLE, counter clears.
  - In IDLE the counter is held at 0.
  - If a timeout and an accepted byte occur in the same cycle, the byte wins and no timeout error is raised.
- Watchdog:
  - The counter decrements by 1 each cycle while nonzero. At 0 it holds, and o_wdt_expired=1.
  - A kick reloads WDT_TIMEOUT and clears o_wdt_expired.
  - If a kick and the reach-zero event occur in the same cycle, the kick wins.
- Asynchronous reset mid-frame aborts the frame. No strobe is emitted, and the counters return to 0.

## Timing
- Accept latency: an accepted byte (o_rreq=1 in cycle N) updates the FSM at the clock edge ending cycle N.
- Result strobes: when the checksum byte is accepted in cycle N, o_cmd_valid, o_wdt_kick or o_err is high in cycle N+1 only.
  - o_frame_cnt and o_err_cnt update in cycle N+1.
  - o_cmd_code/o_cmd_data are valid in cycle N+1 together with o_cmd_valid.
- Throughput: at most one byte every 2 cycles. A back-to-back frame can therefore strobe every 8 cycles.
- Watchdog after a kick: if the kick strobe is in cycle N+1, the counter equals WDT_TIMEOUT in cycle N+1. o_wdt_expired rises WDT_TIMEOUT cycles after that, absent further kicks.
- Timeout detection: a timeout is flagged BYTE_TIMEOUT cycles after the last accepted byte. The o_err strobe is in the following cycle.
- The strobes o_cmd_valid, o_wdt_kick and o_err are mutually exclusive in any cycle.

## Test plan
- Valid frame: bytes 2D 10 AB BB with i_rready pulsed → one o_cmd_valid cycle, code=10, data=AB, o_frame_cnt=1, o_err stays 0.
- Bad checksum: bytes 2D 10 AB 00 → o_err pulse, o_err_code=1, o_err_cnt=1, no o_cmd_valid, code/data unchanged.
- Watchdog, with WDT_TIMEOUT=16:
  - With no kicks, o_wdt_expired rises 16 cycles after reset release.
  - Sending 2D 65 00 65 → o_wdt_kick pulse, o_wdt_expired falls, and it rises again 16 cycles later.
  - No o_cmd_valid throughout.
- Byte timeout, with BYTE_TIMEOUT=20:
  - Send 2D 10, then idle 20 cycles → o_err, o_err_code=2, o_err_cnt=1.
  - A following 2D 22 33 11 decodes correctly.
- Resync and reset:
  - Leading garbage 00 FF 2D 2D 00 2D → one valid frame (code 2D, data 00), no errors.
  - Asserting i_rst_n=0 after 2D 10 → all outputs 0; the next full frame decodes normally.

Source files
------------

// File: rtl/debug_cmd_rx_if.sv
// -----------------------------------------------------------------------------
// debug_cmd_rx_if
// Pop-style handshake between the debug UART RX FIFO and the command receiver.
//   rdata  : byte at the head of the FIFO, meaningful while rready = 1
//   rready : FIFO holds at least one byte
//   rreq   : pop strobe from the receiver; the byte is consumed at the clock
//            edge that ends the strobe cycle
// Modports:
//   master : command receiver side (drives rreq)
//   slave  : FIFO side (drives rdata / rready)
// -----------------------------------------------------------------------------
interface debug_cmd_rx_if;
    logic [7:0] rdata;
    logic       rready;
    logic       rreq;

    modport master (
        input  rdata,
        input  rready,
        output rreq
    );

    modport slave (
        output rdata,
        output rready,
        input  rreq
    );
endinterface

// File: rtl/debug_cmd_rx.sv
// -----------------------------------------------------------------------------
// debug_cmd_rx
// Receive side of the debug UART port. Pops bytes from the RX FIFO, parses
// fixed 4-byte frames (START_BYTE, code, data, code^data), strobes decoded
// commands to user logic and runs a host-kicked watchdog.
//
// Ports:
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   rx              : RX FIFO pop interface (master modport)
//   o_cmd_code/data : last valid non-kick command, held between frames
//   o_cmd_valid     : one-cycle strobe for a valid non-kick frame
//   o_wdt_kick      : one-cycle strobe for a valid kick frame
//   o_wdt_expired   : level, watchdog counter has reached zero
//   o_err           : one-cycle error strobe
//   o_err_code      : 1 = checksum error, 2 = byte timeout (held)
//   o_frame_cnt     : valid frames, wrapping
//   o_err_cnt       : errors, saturating at 255
// -----------------------------------------------------------------------------
module debug_cmd_rx #(
    parameter logic [31:0] WDT_TIMEOUT  = 32'h00682EFF,
    parameter logic [15:0] BYTE_TIMEOUT = 16'd50000,
    parameter logic [7:0]  START_BYTE   = 8'h2D,
    parameter logic [7:0]  KICK_CODE    = 8'h65
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    debug_cmd_rx_if.master        rx,
    output logic [7:0]            o_cmd_code,
    output logic [7:0]            o_cmd_data,
    output logic                  o_cmd_valid,
    output logic                  o_wdt_kick,
    output logic                  o_wdt_expired,
    output logic                  o_err,
    output logic [1:0]            o_err_code,
    output logic [7:0]            o_frame_cnt,
    output logic [7:0]            o_err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CODE  = 2'd1,
        ST_DATA  = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    // Frame checksum: plain XOR of code and data bytes.
    function automatic logic [7:0] frame_checksum(input logic [7:0] code_v,
                                                  input logic [7:0] data_v);
        frame_checksum = code_v ^ data_v;
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [7:0]  code_r;
    logic [7:0]  code_next_s;
    logic [7:0]  data_r;
    logic [7:0]  data_next_s;
    logic [15:0] byte_cnt_r;
    logic [15:0] byte_cnt_next_s;
    logic        rreq_prev_r;
    logic        accept_s;
    logic        good_cmd_s;
    logic        good_kick_s;
    logic        cs_err_s;
    logic        timeout_s;

    logic [31:0] wdt_cnt_r;
    logic        wdt_expired_r;
    logic [7:0]  cmd_code_r;
    logic [7:0]  cmd_data_r;
    logic        cmd_valid_r;
    logic        wdt_kick_r;
    logic        err_r;
    logic [1:0]  err_code_r;
    logic [7:0]  frame_cnt_r;
    logic [7:0]  err_cnt_r;

    // A pop is issued whenever a byte is waiting, but never in two
    // consecutive cycles, so the FIFO has a cycle to present the next head.
    assign accept_s = rx.rready & ~rreq_prev_r;
    assign rx.rreq  = accept_s;

    // Pop history for the one-cycle spacing rule.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rreq_prev_r <= 1'b0;
        end else begin
            rreq_prev_r <= accept_s;
        end
    end

    // Frame parser next-state logic and inter-byte timeout detection.
    always_comb begin
        state_next_s    = state_r;
        code_next_s     = code_r;
        data_next_s     = data_r;
        byte_cnt_next_s = byte_cnt_r;
        good_cmd_s      = 1'b0;
        good_kick_s     = 1'b0;
        cs_err_s        = 1'b0;
        timeout_s       = 1'b0;

        if (accept_s) begin
            // An accepted byte always beats a timeout reached in the same cycle.
            byte_cnt_next_s = 16'd0;
            case (state_r)
                ST_IDLE: begin
                    if (rx.rdata == START_BYTE) begin
                        state_next_s = ST_CODE;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_CODE: begin
                    code_next_s  = rx.rdata;
                    state_next_s = ST_DATA;
                end
                ST_DATA: begin
                    data_next_s  = rx.rdata;
                    state_next_s = ST_CHECK;
                end
                ST_CHECK: begin
                    if (rx.rdata == frame_checksum(code_r, data_r)) begin
                        if (code_r == KICK_CODE) begin
                            good_kick_s = 1'b1;
                        end else begin
                            good_cmd_s = 1'b1;
                        end
                    end else begin
                        cs_err_s = 1'b1;
                    end
                    state_next_s = ST_IDLE;
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end else if (state_r == ST_IDLE) begin
            byte_cnt_next_s = 16'd0;
        end else if (byte_cnt_r == BYTE_TIMEOUT) begin
            timeout_s       = 1'b1;
            state_next_s    = ST_IDLE;
            byte_cnt_next_s = 16'd0;
        end else begin
            byte_cnt_next_s = byte_cnt_r + 16'd1;
        end
    end

    // Parser state, captured frame bytes and inter-byte idle counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= ST_IDLE;
            code_r     <= 8'h00;
            data_r     <= 8'h00;
            byte_cnt_r <= 16'd0;
        end else begin
            state_r    <= state_next_s;
            code_r     <= code_next_s;
            data_r     <= data_next_s;
            byte_cnt_r <= byte_cnt_next_s;
        end
    end

    // Result strobes, held command/error values and frame/error counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cmd_valid_r <= 1'b0;
            wdt_kick_r  <= 1'b0;
            err_r       <= 1'b0;
            cmd_code_r  <= 8'h00;
            cmd_data_r  <= 8'h00;
            err_code_r  <= 2'd0;
            frame_cnt_r <= 8'd0;
            err_cnt_r   <= 8'd0;
        end else begin
            cmd_valid_r <= good_cmd_s;
            wdt_kick_r  <= good_kick_s;
            err_r       <= cs_err_s | timeout_s;
            if (good_cmd_s) begin
                cmd_code_r <= code_r;
                cmd_data_r <= data_r;
            end
            if (cs_err_s) begin
                err_code_r <= 2'd1;
            end else if (timeout_s) begin
                err_code_r <= 2'd2;
            end
            if (good_cmd_s || good_kick_s) begin
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end
            if ((cs_err_s || timeout_s) && (err_cnt_r != 8'hFF)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end
        end
    end

    // Watchdog: counts down to zero and holds; a kick reloads it and takes
    // priority over reaching zero in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wdt_cnt_r     <= WDT_TIMEOUT;
            wdt_expired_r <= 1'b0;
        end else if (good_kick_s) begin
            wdt_cnt_r     <= WDT_TIMEOUT;
            wdt_expired_r <= 1'b0;
        end else if (wdt_cnt_r != 32'd0) begin
            wdt_cnt_r     <= wdt_cnt_r - 32'd1;
            wdt_expired_r <= (wdt_cnt_r == 32'd1);
        end else begin
            wdt_expired_r <= 1'b1;
        end
    end

    assign o_cmd_code    = cmd_code_r;
    assign o_cmd_data    = cmd_data_r;
    assign o_cmd_valid   = cmd_valid_r;
    assign o_wdt_kick    = wdt_kick_r;
    assign o_wdt_expired = wdt_expired_r;
    assign o_err         = err_r;
    assign o_err_code    = err_code_r;
    assign o_frame_cnt   = frame_cnt_r;
    assign o_err_cnt     = err_cnt_r;

endmodule
